// File: rtl/alu_rr_arb.sv
// alu_rr_arb: two valid/ready requesters share one combinational ALU; grants alternate on ties.
// Accept -> EXEC (1 cycle) -> RESP until consumed; `define ALU_OVF_EN adds o_rsp0_ovf/o_rsp1_ovf.

module alu #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   f_i,
`ifdef ALU_OVF_EN
    output logic         ovf_o,
`endif
    output logic [N-1:0] y_o,
    output logic         c_o
);
    // f[2] inverts b and injects the +1, so c is the adder carry-out for every code (a>=b unsigned when f[2]=1)
    logic [N-1:0] b_eff;
    logic [N:0]   sum;
    logic         slt;

    always_comb begin
        b_eff = f_i[2] ? ~b_i : b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, f_i[2]};
        slt   = $signed(a_i) < $signed(b_i);
        case (f_i[1:0])
            2'b00:   y_o = a_i & b_eff;
            2'b01:   y_o = a_i | b_eff;
            2'b10:   y_o = sum[N-1:0];
            default: y_o = f_i[2] ? {{(N-1){1'b0}}, slt} : '0;
        endcase
    end

    assign c_o = sum[N];

`ifdef ALU_OVF_EN
    assign ovf_o = (f_i[1:0] == 2'b10) && (a_i[N-1] == b_eff[N-1]) && (sum[N-1] != a_i[N-1]);
`endif

endmodule

module alu_rr_arb #(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [N-1:0] i_req0_a,
    input  logic [N-1:0] i_req0_b,
    input  logic [2:0]   i_req0_f,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [N-1:0] i_req1_a,
    input  logic [N-1:0] i_req1_b,
    input  logic [2:0]   i_req1_f,
    output logic         o_rsp0_valid,
    input  logic         i_rsp0_ready,
    output logic [N-1:0] o_rsp0_y,
    output logic         o_rsp0_c,
    output logic         o_rsp1_valid,
    input  logic         i_rsp1_ready,
    output logic [N-1:0] o_rsp1_y,
    output logic         o_rsp1_c,
`ifdef ALU_OVF_EN
    output logic         o_rsp0_ovf,
    output logic         o_rsp1_ovf,
`endif
    output logic         o_busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t       state_q;
    logic         last_gnt_q;
    logic         gnt_id_q;
    logic         gnt_d;
    logic         accept;
    logic         rsp_rdy;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic [2:0]   op_f_q, op_f_d;
    logic [N-1:0] alu_y;
    logic         alu_c;
    logic [N-1:0] res_y_q;
    logic         res_c_q;
    logic [1:0]   rsp_vld_q;
`ifdef ALU_OVF_EN
    logic         alu_ovf;
    logic         res_ovf_q;
`endif

    // On a tie the requester not served last wins; otherwise whichever is valid
    always_comb begin
        gnt_d = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            gnt_d = ~last_gnt_q;
        end else if (i_req1_valid) begin
            gnt_d = 1'b1;
        end
        op_a_d = gnt_d ? i_req1_a : i_req0_a;
        op_b_d = gnt_d ? i_req1_b : i_req0_b;
        op_f_d = gnt_d ? i_req1_f : i_req0_f;
    end

    assign accept       = (state_q == IDLE) && (i_req0_valid || i_req1_valid);
    assign o_req0_ready = (state_q == IDLE) && i_req0_valid && !gnt_d;
    assign o_req1_ready = (state_q == IDLE) && i_req1_valid && gnt_d;
    assign rsp_rdy      = gnt_id_q ? i_rsp1_ready : i_rsp0_ready;

    alu #(.N(N)) u_alu (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .f_i   (op_f_q),
`ifdef ALU_OVF_EN
        .ovf_o (alu_ovf),
`endif
        .y_o   (alu_y),
        .c_o   (alu_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_id_q   <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_f_q     <= '0;
            res_y_q    <= '0;
            res_c_q    <= 1'b0;
            rsp_vld_q  <= 2'b00;
`ifdef ALU_OVF_EN
            res_ovf_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q     <= op_a_d;
                        op_b_q     <= op_b_d;
                        op_f_q     <= op_f_d;
                        gnt_id_q   <= gnt_d;
                        last_gnt_q <= gnt_d;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    res_y_q   <= alu_y;
                    res_c_q   <= alu_c;
`ifdef ALU_OVF_EN
                    res_ovf_q <= alu_ovf;
`endif
                    rsp_vld_q <= gnt_id_q ? 2'b10 : 2'b01;
                    state_q   <= RESP;
                end
                RESP: begin
                    // No bypass: the next accept waits for the IDLE cycle
                    if (rsp_rdy) begin
                        rsp_vld_q <= 2'b00;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    rsp_vld_q <= 2'b00;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_rsp0_valid = rsp_vld_q[0];
    assign o_rsp1_valid = rsp_vld_q[1];
    assign o_rsp0_y     = res_y_q;
    assign o_rsp1_y     = res_y_q;
    assign o_rsp0_c     = res_c_q;
    assign o_rsp1_c     = res_c_q;
`ifdef ALU_OVF_EN
    assign o_rsp0_ovf   = res_ovf_q;
    assign o_rsp1_ovf   = res_ovf_q;
`endif
    assign o_busy       = (state_q != IDLE);

    a_req_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_req0_ready && o_req1_ready));
    a_rsp_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_rsp0_valid && o_rsp1_valid));
    a_rsp_in_resp: assert property (@(posedge i_clk) disable iff (i_rst)
        ((|rsp_vld_q) == (state_q == RESP)));

endmodule

// File: tb/tb_alu_rr_arb.sv
// tb_alu_rr_arb: scoreboard bench; arbitration/timing model predicts each accept, monitor checks responses.
module tb_alu_rr_arb;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_f, req1_f;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [N-1:0] rsp0_y, rsp1_y;
    logic         rsp0_c, rsp1_c, busy;
`ifdef ALU_OVF_EN
    logic         rsp0_ovf, rsp1_ovf;
`endif

    alu_rr_arb #(.N(N)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_a     (req0_a),
        .i_req0_b     (req0_b),
        .i_req0_f     (req0_f),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_a     (req1_a),
        .i_req1_b     (req1_b),
        .i_req1_f     (req1_f),
        .o_rsp0_valid (rsp0_valid),
        .i_rsp0_ready (rsp0_ready),
        .o_rsp0_y     (rsp0_y),
        .o_rsp0_c     (rsp0_c),
        .o_rsp1_valid (rsp1_valid),
        .i_rsp1_ready (rsp1_ready),
        .o_rsp1_y     (rsp1_y),
        .o_rsp1_c     (rsp1_c),
`ifdef ALU_OVF_EN
        .o_rsp0_ovf   (rsp0_ovf),
        .o_rsp1_ovf   (rsp1_ovf),
`endif
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           ch;
        logic [N-1:0] y;
        bit           c;
        bit           ovf;
        int           acc;
    } resp_t;

    resp_t        exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           acc_cyc = -1;
    int           done_cyc = -1;
    bit           last_srv = 1'b1;
    bit [1:0]     acc_last;
    logic [N-1:0] held_y = '0;
    bit           held_c = 1'b0;
    bit           held_ovf = 1'b0;
    bit           mv0, mv1, mc, mo;
    logic [N-1:0] my;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %b, want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Reference: operation meanings written directly as arithmetic
    function automatic resp_t ref_op(input bit ch, input logic [N-1:0] a, input logic [N-1:0] b,
                                     input logic [2:0] f);
        resp_t      r;
        logic [N:0] s;
        r.ch  = ch;
        r.acc = 0;
        s     = {1'b0, a} + {1'b0, b};
        r.c   = f[2] ? (a >= b) : s[N];
        case (f)
            3'd0:    r.y = a & b;
            3'd1:    r.y = a | b;
            3'd2:    r.y = a + b;
            3'd4:    r.y = a & ~b;
            3'd5:    r.y = a | ~b;
            3'd6:    r.y = a - b;
            3'd7:    r.y = ($signed(a) < $signed(b)) ? 1 : 0;
            default: r.y = '0;
        endcase
        r.ovf = 1'b0;
        if (f == 3'd2) r.ovf = (a[N-1] == b[N-1]) && (r.y[N-1] != a[N-1]);
        if (f == 3'd6) r.ovf = (a[N-1] != b[N-1]) && (r.y[N-1] != a[N-1]);
        return r;
    endfunction

    // Arbitration model evaluated at each negedge: who should be accepted now, if anyone
    task automatic eval();
        bit idle, win, er0, er1;
        resp_t r;
        if (rst) return;
        idle = (acc_cyc < 0) || (done_cyc >= acc_cyc + 2 && done_cyc < cyc);
        if (req0_valid && req1_valid) win = ~last_srv;
        else                          win = req1_valid;
        er0 = idle && req0_valid && !win;
        er1 = idle && req1_valid && win;
        chk1("req0_ready", req0_ready, er0);
        chk1("req1_ready", req1_ready, er1);
        chk1("busy", busy, !idle);
        if (er0 || er1) begin
            r = er1 ? ref_op(1'b1, req1_a, req1_b, req1_f) : ref_op(1'b0, req0_a, req0_b, req0_f);
            r.acc = cyc;
            exp_q.push_back(r);
            acc_cyc = cyc;
            last_srv = er1;
            acc_last[er1] = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mv0 = 1'b0; mv1 = 1'b0;
                my = held_y; mc = held_c; mo = held_ovf;
                if (exp_q.size() > 0 && cyc - exp_q[0].acc >= 2) begin
                    my = exp_q[0].y; mc = exp_q[0].c; mo = exp_q[0].ovf;
                    if (exp_q[0].ch) mv1 = 1'b1;
                    else             mv0 = 1'b1;
                end
                chk1("rsp0_valid", rsp0_valid, mv0);
                chk1("rsp1_valid", rsp1_valid, mv1);
                chk32("rsp0_y", rsp0_y, my);
                chk32("rsp1_y", rsp1_y, my);
                chk1("rsp0_c", rsp0_c, mc);
                chk1("rsp1_c", rsp1_c, mc);
`ifdef ALU_OVF_EN
                chk1("rsp0_ovf", rsp0_ovf, mo);
                chk1("rsp1_ovf", rsp1_ovf, mo);
`endif
                if ((mv0 && rsp0_ready) || (mv1 && rsp1_ready)) begin
                    held_y = my; held_c = mc; held_ovf = mo;
                    void'(exp_q.pop_front());
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        acc_last = 2'b00;
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
        if (acc_last[0]) req0_valid = 1'b0;
        if (acc_last[1]) req1_valid = 1'b0;
    endtask

    task automatic settle(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || req0_valid || req1_valid) && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic set_req(input bit ch, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2:0] f);
        if (ch) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
        end
    endtask

    function automatic logic [N-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return '0;
            4:       return N'($urandom_range(0, 15));
            default: return N'($urandom());
        endcase
    endfunction

    task automatic reset_checks();
        chk1("rst rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst rsp1_valid", rsp1_valid, 1'b0);
        chk32("rst rsp0_y", rsp0_y, '0);
        chk32("rst rsp1_y", rsp1_y, '0);
        chk1("rst rsp0_c", rsp0_c, 1'b0);
        chk1("rst rsp1_c", rsp1_c, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst req0_ready", req0_ready, 1'b0);
        chk1("rst req1_ready", req1_ready, 1'b0);
`ifdef ALU_OVF_EN
        chk1("rst rsp0_ovf", rsp0_ovf, 1'b0);
        chk1("rst rsp1_ovf", rsp1_ovf, 1'b0);
`endif
    endtask

    task automatic model_clear();
        exp_q.delete();
        acc_cyc = -1; done_cyc = -1; last_srv = 1'b1;
        held_y = '0; held_c = 1'b0; held_ovf = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b1;
        #1;
        reset_checks();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_f = '0;
        req1_a = '0; req1_b = '0; req1_f = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        model_clear();
        rst = 1'b0;

        set_req(1'b0, 32'd5, 32'd3, 3'b010);
        settle(20);

        set_req(1'b0, 32'd3, 32'd5, 3'b110);
        set_req(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        settle(20);

        set_req(1'b0, rnd_opnd(), rnd_opnd(), 3'b010);
        set_req(1'b1, rnd_opnd(), rnd_opnd(), 3'b110);
        n = 0; k = 0;
        while (n < 4 && k < 40) begin
            tick();
            k++;
            if (acc_last[0]) begin n++; set_req(1'b0, rnd_opnd(), rnd_opnd(), 3'b111); end
            if (acc_last[1]) begin n++; set_req(1'b1, rnd_opnd(), rnd_opnd(), 3'b101); end
        end
        settle(40);

        rsp0_ready = 1'b0;
        set_req(1'b0, rnd_opnd(), rnd_opnd(), 3'b010);
        tick(); tick();
        set_req(1'b0, 32'h1234, 32'h0FF0, 3'b000);
        set_req(1'b1, 32'h8000_0000, 32'd1, 3'b110);
        repeat (5) tick();
        rsp0_ready = 1'b1;
        settle(30);

        set_req(1'b1, 32'hF0, 32'h3C, 3'b011);
        settle(20);
        set_req(1'b0, 32'hF0, 32'h3C, 3'b100);
        settle(20);

        set_req(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010);
        settle(20);
        rsp0_ready = 1'b0;
        set_req(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010);
        repeat (4) tick();
        do_reset();
        rsp0_ready = 1'b1;
        repeat (6) tick();
        set_req(1'b0, 32'd9, 32'd4, 3'b110);
        set_req(1'b1, 32'd2, 32'd7, 3'b001);
        settle(20);

        for (int i = 0; i < 2500; i++) begin
            if (!req0_valid) begin
                if ($urandom_range(0, 99) < 35) set_req(1'b0, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
            end else if ($urandom_range(0, 99) < 4) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid) begin
                if ($urandom_range(0, 99) < 35) set_req(1'b1, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
            end else if ($urandom_range(0, 99) < 4) begin
                req1_valid = 1'b0;
            end
            rsp0_ready = ($urandom_range(0, 99) < 65);
            rsp1_ready = ($urandom_range(0, 99) < 65);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        settle(20);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
